// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side sequencer for a UART.
// Accepts one payload byte per valid/ready handshake and assembles the serial
// frame {stop, [parity], data, start}. It drives the load and shift strobes of
// a downstream piso (R=1), whose bit 0 is the TX line. This block owns the baud
// timing and the bit counting.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the payload MSB and the stop bit. The frame then grows from N+2 to N+3 bits.
//
// Handshake: a byte transfers on any cycle where i_valid && o_ready are both 1.
// o_ready is registered and is high only in IDLE. o_piso_we is that handshake,
// combinationally, so the piso loads the frame on the same edge that the
// transfer is taken.
module uart_tx_ctrl #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16,
`ifdef UART_TX_PARITY_EN
    localparam int W           = N + 3
`else
    localparam int W           = N + 2
`endif
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_data,
    output logic         o_piso_we,
    output logic         o_piso_shift,
    output logic [W-1:0] o_piso_data,
    output logic         o_busy,
    output logic         o_done
);

    localparam int BCW = $clog2(W + 1);
    localparam int BDW = $clog2(CLKS_PER_BIT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t         state;
    logic [BDW-1:0] baud_cnt;
    logic [BCW-1:0] bit_cnt;
    logic           ready_q;
    logic           busy_q;

    logic           handshake;
    logic           baud_wrap;
    logic           last_bit;

    // Frame word, with the line's first bit (start) at bit 0.
`ifdef UART_TX_PARITY_EN
    assign o_piso_data = {1'b1, ^i_data, i_data, 1'b0};
`else
    assign o_piso_data = {1'b1, i_data, 1'b0};
`endif

    // Strobe decodes: load on the handshake, shift at the end of each bit period.
    assign handshake    = i_valid && ready_q;
    assign baud_wrap    = (state == S_SEND) && (baud_cnt == BDW'(CLKS_PER_BIT - 1));
    assign last_bit     = (bit_cnt == BCW'(W - 1));

    assign o_piso_we    = handshake;
    assign o_piso_shift = baud_wrap;
    assign o_done       = baud_wrap && last_bit;
    assign o_ready      = ready_q;
    assign o_busy       = busy_q;

    // FSM: IDLE waits for a byte; SEND counts W bit periods, then returns to IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        state    <= S_SEND;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end else begin
                        ready_q  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (last_bit) begin
                            // The W-th shift has moved the stop bit out. The line
                            // now holds the R=1 fill, so the frame is over.
                            state   <= S_IDLE;
                            bit_cnt <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BDW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl (N=8, CLKS_PER_BIT=4), with a behavioural piso on
// the strobes. Compile with UART_TX_PARITY_EN to cover the parity build.
module tb_uart_tx_ctrl;

    localparam int N = 8;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int W = N + 3;
`else
    localparam int W = N + 2;
`endif

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_data;
    logic         o_piso_we;
    logic         o_piso_shift;
    logic [W-1:0] o_piso_data;
    logic         o_busy;
    logic         o_done;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    logic [W-1:0] exp_q[$];

    uart_tx_ctrl #(.N(N), .CLKS_PER_BIT(C)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_piso_we    (o_piso_we),
        .o_piso_shift (o_piso_shift),
        .o_piso_data  (o_piso_data),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // ---- clock / reset block
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural downstream piso: the line is bit 0, and shifts fill with 1.
    logic [W-1:0] piso_q;
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst)             piso_q <= '1;
        else if (o_piso_we)    piso_q <= o_piso_data;
        else if (o_piso_shift) piso_q <= {1'b1, piso_q[W-1:1]};
    end
    wire line = piso_q[0];

    // Load and shift are never requested together.
    always @(negedge i_clk) begin
        if (i_rst === 1'b0) begin
            checks++;
            if (o_piso_we && o_piso_shift) begin
                errors++;
                $display("FAIL we_shift_overlap at t=%0t: we=%b shift=%b, need not both 1",
                         $time, o_piso_we, o_piso_shift);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // Reference frame: start 0, payload LSB first, optional even parity, stop 1.
    function automatic logic [W-1:0] exp_frame(input logic [N-1:0] d);
        logic [W-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < N; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[N+1] = ^d;
`endif
        return f;
    endfunction

    // ---- driver task: offer byte d, then follow the whole frame bit by bit.
    // The task returns at posedge+1 of the cycle after o_done.
    // hold  : keep i_valid high through the frame.
    // noise : toggle i_valid randomly during SEND.
    task automatic run_frame(input logic [N-1:0] d, input bit hold, input bit noise,
                             output int hs_cycle);
        int guard;
        int shifts;
        logic [W-1:0] f;
        i_valid = 1'b1;
        i_data  = d;
        #1;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 200) begin
            @(posedge i_clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL accept_timeout: o_ready=%b after %0d cycles, need 1", o_ready, guard);
            i_valid = 1'b0;
            hs_cycle = -1;
            return;
        end
        hs_cycle = cyc_cnt;
        exp_q.push_back(exp_frame(d));
        checks++;
        if (o_piso_we !== 1'b1) begin
            errors++;
            $display("FAIL load_strobe: o_piso_we=%b need 1", o_piso_we);
        end
        checks++;
        if (o_piso_data !== exp_q[0]) begin
            errors++;
            $display("FAIL frame_word: got %b need %b", o_piso_data, exp_q[0]);
        end
        @(posedge i_clk); #1;
        i_data = N'($urandom);
        if (!hold) i_valid = 1'b0;
        f = exp_q[0];
        shifts = 0;
        for (int c = 1; c <= W * C; c++) begin
            checks++;
            if (o_piso_shift !== ((c % C) == 0)) begin
                errors++;
                $display("FAIL shift_c%0d: got %b need %b", c, o_piso_shift, (c % C) == 0);
            end
            checks++;
            if (o_done !== (c == W * C)) begin
                errors++;
                $display("FAIL done_c%0d: got %b need %b", c, o_done, c == W * C);
            end
            checks++;
            if (o_busy !== 1'b1 || o_ready !== 1'b0 || o_piso_we !== 1'b0) begin
                errors++;
                $display("FAIL send_flags_c%0d: busy=%b ready=%b we=%b need 1,0,0",
                         c, o_busy, o_ready, o_piso_we);
            end
            checks++;
            if (line !== f[(c-1)/C]) begin
                errors++;
                $display("FAIL line_c%0d: got %b need %b (bit %0d)", c, line, f[(c-1)/C], (c-1)/C);
            end
            if (o_piso_shift === 1'b1) shifts++;
            if (noise) i_valid = (c == W * C) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge i_clk); #1;
        end
        void'(exp_q.pop_front());
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || line !== 1'b1) begin
            errors++;
            $display("FAIL frame_end: ready=%b busy=%b done=%b line=%b need 1,0,0,1",
                     o_ready, o_busy, o_done, line);
        end
        checks++;
        if (shifts != W) begin
            errors++;
            $display("FAIL shift_count: got %0d need %0d", shifts, W);
        end
        checks++;
        if (o_piso_we !== hold) begin
            errors++;
            $display("FAIL next_accept: we=%b need %b", o_piso_we, hold);
        end
    endtask

    // ---- scenario tasks
    task automatic test_reset();
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h5A;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_piso_we !== 1'b0 || o_piso_shift !== 1'b0 ||
            o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%b shift=%b busy=%b done=%b need all 0",
                     o_ready, o_piso_we, o_piso_shift, o_busy, o_done);
        end
        checks++;
        if (o_piso_data !== exp_frame(8'h5A)) begin
            errors++;
            $display("FAIL reset_data_follow: got %b need %b", o_piso_data, exp_frame(8'h5A));
        end
        i_valid = 1'b0;
        i_rst   = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b need 0", o_ready);
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_ready !== 1'b1 || o_piso_we !== 1'b0 || o_piso_shift !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_release: ready=%b we=%b shift=%b need 1,0,0",
                     o_ready, o_piso_we, o_piso_shift);
        end
    endtask

    task automatic test_single_frame();
        int hs;
        logic [W-1:0] lit;
`ifdef UART_TX_PARITY_EN
        lit = 11'b1_0_10100101_0;
`else
        lit = 10'b1_10100101_0;
`endif
        i_valid = 1'b1;
        i_data  = 8'hA5;
        #1;
        checks++;
        if (o_piso_data !== lit) begin
            errors++;
            $display("FAIL a5_literal: got %b need %b", o_piso_data, lit);
        end
        run_frame(8'hA5, 1'b0, 1'b0, hs);
    endtask

    task automatic test_two_frames();
        int hs0, hs1;
        logic [W-1:0] lit;
`ifdef UART_TX_PARITY_EN
        lit = 11'b1_1_00000111_0;
`else
        lit = 10'b1_00000111_0;
`endif
        checks++;
        if (exp_frame(8'h07) !== lit) begin
            errors++;
            $display("FAIL ref_frame_07: got %b need %b", exp_frame(8'h07), lit);
        end
        run_frame(8'hA5, 1'b1, 1'b0, hs0);
        run_frame(8'h07, 1'b0, 1'b0, hs1);
        checks++;
        if (hs1 - hs0 != W * C + 1) begin
            errors++;
            $display("FAIL second_accept: gap %0d need %0d", hs1 - hs0, W * C + 1);
        end
    endtask

    task automatic test_back_to_back();
        int hs_prev, hs;
        run_frame(8'h3C, 1'b1, 1'b0, hs_prev);
        for (int k = 0; k < 3; k++) begin
            run_frame(8'h3C, (k != 2), 1'b0, hs);
            checks++;
            if (hs - hs_prev != W * C + 1) begin
                errors++;
                $display("FAIL b2b_gap_%0d: got %0d need %0d", k, hs - hs_prev, W * C + 1);
            end
            hs_prev = hs;
        end
    endtask

    task automatic test_valid_ignored();
        int hs;
        run_frame(N'($urandom), 1'b0, 1'b1, hs);
        run_frame(N'($urandom), 1'b0, 1'b1, hs);
    endtask

    task automatic test_reset_mid_frame();
        int hs;
        int guard;
        i_valid = 1'b1;
        i_data  = 8'hC3;
        #1;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 200) begin
            @(posedge i_clk); #1;
            guard++;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (16) @(posedge i_clk);
        #1;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: got %b need 1", o_busy);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_piso_shift !== 1'b0 || o_ready !== 1'b0 ||
            o_done !== 1'b0 || o_piso_we !== 1'b0 || line !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: busy=%b shift=%b ready=%b done=%b we=%b line=%b need 0,0,0,0,0,1",
                     o_busy, o_piso_shift, o_ready, o_done, o_piso_we, line);
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        run_frame(8'h96, 1'b0, 1'b0, hs);
    endtask

    task automatic test_random();
        int hs;
        for (int k = 0; k < 6; k++) begin
            bit h;
            h = (k != 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_frame(N'($urandom), h, h ? 1'b0 : 1'($urandom_range(0, 1)), hs);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        test_reset();
        test_single_frame();
        test_two_frames();
        test_back_to_back();
        test_valid_ignored();
        test_reset_mid_frame();
        test_random();
        repeat (3) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencer for the UART transmit path: accepts bytes over a valid/ready handshake, builds a serial frame and drives the load/shift controls of a downstream `piso` instance (R=1, width = frame width) whose serial output is the TX line. The block owns baud timing, bit counting and frame assembly; the shift register itself stays a plain datapath element. It sits between the bus-side TX holding register and the `piso`.

## Interface
- `N`, 8, payload bits per frame (≥1).
- `CLKS_PER_BIT`, 16, clock cycles per serial bit (≥2).
- `W` (localparam), N+2 (N+3 with parity), frame width = width of `o_piso_data`.

- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  byte available on `i_data`.
- `o_ready`  out  1  controller idle, able to accept a byte.
- `i_data`  in  N  payload, sent LSB first.
- `o_piso_we`  out  1  load strobe to `piso.i_we`.
- `o_piso_shift`  out  1  shift strobe to `piso.i_shift`.
- `o_piso_data`  out  W  frame word to `piso.i_data`.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle pulse, frame complete.

## Operation
- States: IDLE, SEND.
- Frame word, bit 0 first on line: {stop=1, [parity], i_data[N-1:0], start=0}. `o_piso_data` is combinational from `i_data`; valid whenever `o_piso_we`=1.
- IDLE: `o_ready`=1. Handshake = `i_valid && o_ready`. `o_piso_we` = handshake (combinational, one cycle). On the handshake edge: state→SEND, baud counter←0, bit counter←0.
- SEND: baud counter increments each cycle; at count CLKS_PER_BIT-1 it wraps to 0 and `o_piso_shift` pulses for that cycle, bit counter increments.
- The W-th shift ends the frame: `o_done` pulses in the same cycle as that shift; state→IDLE on that edge. The last shift pulls R=1 into the `piso`, keeping the line idle-high.
- `o_piso_we` and `o_piso_shift` are never high in the same cycle.
- `i_valid` in SEND is ignored; `i_data` need not be held after the handshake.
- Bit counter width = $clog2(W+1); baud counter width = $clog2(CLKS_PER_BIT).

## Timing
- Reset values: state IDLE, counters 0, `o_ready`=0, `o_piso_we`=0, `o_piso_shift`=0, `o_busy`=0, `o_done`=0. `o_piso_data` follows `i_data`.
- `o_ready` is registered: rises on the first clock edge after `i_rst` deasserts, falls on the handshake edge, rises on the edge that ends the frame.
- Handshake at cycle 0: line shows start bit from cycle 1. Shifts occur at cycles k·CLKS_PER_BIT for k=1..W. `o_done` occurs at cycle W·CLKS_PER_BIT. `o_ready`=1 from cycle W·CLKS_PER_BIT+1.
- Back-to-back: a byte held valid is accepted on cycle W·CLKS_PER_BIT+1. Each bit lasts exactly CLKS_PER_BIT cycles with no gap between frames other than one idle cycle.
- `o_busy` = state==SEND (registered via state).
- Reset mid-frame: all outputs drop to reset values immediately, with no `o_done`. The `piso` shares `i_rst` and returns to all-ones.

## Configuration
- `UART_TX_PARITY_EN` defined: W=N+3, and an even-parity bit (^i_data) is inserted between the MSB and the stop bit.
- Not defined: W=N+2, no parity bit, and no parity logic is synthesised.

## Test plan
- Reset release, N=8, CLKS_PER_BIT=4: `o_ready` 0 during reset, 1 one cycle after release; all strobes 0.
- Send 0xA5 without parity: `o_piso_we`=1 in cycle 0 with `o_piso_data`=10'b1_10100101_0. Shifts at 4,8,…,40, `o_done` at 40, `o_ready` at 41. Serial line bits are 0,1,0,1,0,0,1,0,1,1.
- With `UART_TX_PARITY_EN`, send 0xA5 then 0x07: frames 11'b1_0_10100101_0 and 11'b1_1_00000111_0. Shifts end at 44; the second byte is accepted at 45.
- `i_valid` held high continuously with 0x3C: accepts every W·4+1 cycles. `i_valid` pulsed during SEND is ignored, with no extra `o_piso_we`.
- Assert `i_rst` at cycle 17 of a frame: `o_busy`, `o_piso_shift` and `o_ready` are 0 immediately. After release, the next handshake starts a full fresh frame.
- Assertion across all runs: `o_piso_we` && `o_piso_shift` is never 1. Shift count per frame = W.
